ospfb_fft_ctrl: RTL and testbench

OSPFB_FFT_CTRL -- requirements
Module: ospfb_fft_ctrl

---
 rtl/ospfb_pkg.sv | 14 +
 rtl/axis.sv | 11 +
 rtl/ospfb_fft_ctrl_sat_counter.sv | 20 ++
 rtl/ospfb_fft_ctrl.sv | 153 +++++++++++++++
 tb/tb_ospfb_fft_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ospfb_pkg.sv
// Shared types for the OSPFB FFT control path.
package ospfb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIG  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RUN     = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

endpackage

// File: rtl/axis.sv
// Minimal AXI-Stream channel (no tlast/tkeep) for the FFT config port.
interface axis #(
    parameter int W = 8
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport MST (output tdata, output tvalid, input tready);
    modport SLV (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ospfb_fft_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ospfb_fft_ctrl.sv
// Sequences FFT core configuration, OSPFB enable and error recovery.
module ospfb_fft_ctrl
    import ospfb_pkg::*;
#(
    parameter int                      FFT_CONF_WID = 8,
    parameter logic [FFT_CONF_WID-1:0] DEFAULT_CONF = 8'h01,
    parameter int                      WAIT_TIMEOUT = 4096,
    parameter int                      FLUSH_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [FFT_CONF_WID-1:0] conf_word,
    input  logic                    conf_update,
    input  logic                    event_frame_started,
    input  logic                    event_tlast_unexpected,
    input  logic                    event_tlast_missing,
    input  logic                    event_fft_overflow,
    input  logic                    event_data_in_channel_halt,
    axis.MST                        m_axis_config,
    output logic                    ospfb_en,
    output logic [STATE_W-1:0]      state,
    output logic [31:0]             frame_count,
    output logic [15:0]             overflow_count,
    output logic [15:0]             halt_count,
    output logic                    sync_err,
    output logic                    timeout_err
);

    state_t                  cur_state;
    state_t                  nxt_state;
    logic [31:0]             tmr;
    logic [FFT_CONF_WID-1:0] shadow;
    logic [FFT_CONF_WID-1:0] tdata_r;
    logic                    en_nx;
    logic                    set_sync;
    logic                    set_tmo;
    logic                    clr;
    logic                    active;
    logic                    xfer;
    logic                    cfg_entry;

    assign active = (cur_state == ST_WAIT) || (cur_state == ST_RUN);
    assign clr    = (cur_state == ST_IDLE) && start;
    assign xfer   = m_axis_config.tvalid && m_axis_config.tready;
    assign cfg_entry = (nxt_state == ST_CONFIG) && (cur_state != ST_CONFIG);

    assign m_axis_config.tvalid = (cur_state == ST_CONFIG);
    assign m_axis_config.tdata  = tdata_r;
    assign state                = cur_state;

    always_comb begin
        nxt_state = cur_state;
        set_sync  = 1'b0;
        set_tmo   = 1'b0;
        unique case (cur_state)
            ST_IDLE: begin
                if (start) nxt_state = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (stop)      nxt_state = ST_IDLE;
                else if (xfer) nxt_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (stop) begin
                    nxt_state = ST_IDLE;
                end else if (event_frame_started) begin
                    nxt_state = ST_RUN;
                end else if (tmr == 32'(WAIT_TIMEOUT - 1)) begin
                    nxt_state = ST_RECOVER;
                    set_tmo   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    nxt_state = ST_IDLE;
                end else if (event_tlast_unexpected || event_tlast_missing) begin
                    nxt_state = ST_RECOVER;
                    set_sync  = 1'b1;
                end else if (conf_update) begin
                    nxt_state = ST_CONFIG;
                end
            end
            ST_RECOVER: begin
                if (stop) begin
                    nxt_state = ST_IDLE;
                end else if (tmr == 32'(FLUSH_CYCLES - 1)) begin
                    nxt_state = ST_CONFIG;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // CONFIG keeps whatever enable the previous state left behind
    always_comb begin
        en_nx = 1'b0;
        unique case (nxt_state)
            ST_WAIT, ST_RUN: en_nx = 1'b1;
            ST_CONFIG:       en_nx = ospfb_en;
            default:         en_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= ST_IDLE;
            tmr         <= '0;
            shadow      <= DEFAULT_CONF;
            tdata_r     <= DEFAULT_CONF;
            ospfb_en    <= 1'b0;
            frame_count <= '0;
            sync_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            tmr       <= (nxt_state != cur_state) ? '0 : tmr + 1'b1;
            ospfb_en  <= en_nx;
            if (conf_update) shadow <= conf_word;
            // a same-cycle update must win over the stale shadow
            if (cfg_entry) tdata_r <= conf_update ? conf_word : shadow;
            if (clr) begin
                frame_count <= '0;
                sync_err    <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (active && event_frame_started) begin
                    frame_count <= frame_count + 1'b1;
                end
                if (set_sync) sync_err <= 1'b1;
                if (set_tmo)  timeout_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(16)) u_ovf_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (active && event_fft_overflow),
        .count (overflow_count)
    );

    sat_counter #(.W(16)) u_halt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (active && event_data_in_channel_halt),
        .count (halt_count)
    );

endmodule

// File: tb/tb_ospfb_fft_ctrl.sv
// Directed self-checking bench for ospfb_fft_ctrl.
module tb_ospfb_fft_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  conf_word;
    logic        conf_update;
    logic        ev_fs;
    logic        ev_tu;
    logic        ev_tm;
    logic        ev_ov;
    logic        ev_halt;
    logic        ospfb_en;
    logic [2:0]  state;
    logic [31:0] frame_count;
    logic [15:0] overflow_count;
    logic [15:0] halt_count;
    logic        sync_err;
    logic        timeout_err;

    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    logic [7:0]  last_beat = 8'hxx;

    axis #(.W(8)) cfg_if ();

    ospfb_fft_ctrl dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .stop                       (stop),
        .conf_word                  (conf_word),
        .conf_update                (conf_update),
        .event_frame_started        (ev_fs),
        .event_tlast_unexpected     (ev_tu),
        .event_tlast_missing        (ev_tm),
        .event_fft_overflow         (ev_ov),
        .event_data_in_channel_halt (ev_halt),
        .m_axis_config              (cfg_if),
        .ospfb_en                   (ospfb_en),
        .state                      (state),
        .frame_count                (frame_count),
        .overflow_count             (overflow_count),
        .halt_count                 (halt_count),
        .sync_err                   (sync_err),
        .timeout_err                (timeout_err)
    );

    always #5 clk = ~clk;

    // a beat seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && cfg_if.tvalid && cfg_if.tready) begin
            beats     <= beats + 1;
            last_beat <= cfg_if.tdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        ev_fs = 1'b1;
        tick();
        ev_fs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int n;
        int b0;
        rst = 1'b1; start = 0; stop = 0; conf_word = 8'h00;
        conf_update = 0; ev_fs = 0; ev_tu = 0; ev_tm = 0;
        ev_ov = 0; ev_halt = 0; cfg_if.tready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_tvalid", cfg_if.tvalid, 0);
        chk("rst_tdata", cfg_if.tdata, 8'h01);
        chk("rst_en", ospfb_en, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_halt", halt_count, 0);
        chk("rst_serr", sync_err, 0);
        chk("rst_terr", timeout_err, 0);

        start = 1'b1; tick(); start = 1'b0;
        chk("cfg_state", state, 1);
        chk("cfg_tvalid", cfg_if.tvalid, 1);
        chk("cfg_tdata", cfg_if.tdata, 8'h01);
        tick();
        chk("wait_state", state, 2);
        chk("wait_en", ospfb_en, 1);
        chk("wait_tvalid", cfg_if.tvalid, 0);
        chk("beat1_n", beats, 1);
        chk("beat1_d", last_beat, 8'h01);
        repeat (7) tick();
        frame();
        chk("run_state", state, 3);
        chk("run_fc", frame_count, 1);

        conf_word = 8'h00; conf_update = 1'b1; tick(); conf_update = 1'b0;
        chk("upd_state", state, 1);
        chk("upd_en", ospfb_en, 1);
        chk("upd_tdata", cfg_if.tdata, 8'h00);
        tick();
        chk("upd_beat_n", beats, 2);
        chk("upd_beat_d", last_beat, 8'h00);
        chk("upd_wait_en", ospfb_en, 1);
        frame();
        chk("run2_fc", frame_count, 2);

        ev_tm = 1'b1; tick(); ev_tm = 1'b0;
        chk("rec_state", state, 4);
        chk("rec_serr", sync_err, 1);
        n = 0;
        while (state == 3'd4 && n < 200) begin
            if (!ospfb_en) n++;
            tick();
        end
        chk("rec_len", n, 64);
        chk("rec_cfg", state, 1);
        chk("rec_cfg_en", ospfb_en, 0);
        tick();
        chk("rec_beat_n", beats, 3);
        chk("rec_wait", state, 2);
        chk("rec_wait_en", ospfb_en, 1);
        frame();
        chk("rec_run", state, 3);

        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_state", state, 0);
        chk("stop_en", ospfb_en, 0);
        cfg_if.tready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_fc", frame_count, 0);
        chk("restart_serr", sync_err, 0);
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            chk("hold_tvalid", cfg_if.tvalid, 1);
            chk("hold_tdata", cfg_if.tdata, 8'h00);
            conf_word   = 8'hA5;
            conf_update = (i == 1);
            tick();
        end
        conf_update = 1'b0;
        chk("hold_nobeat", beats, b0);
        chk("hold_tdata6", cfg_if.tdata, 8'h00);
        cfg_if.tready = 1'b1;
        tick();
        chk("hold_beat_n", beats, b0 + 1);
        chk("hold_beat_d", last_beat, 8'h00);
        chk("hold_wait", state, 2);

        n = 0;
        while (state == 3'd2 && n < 5000) begin
            n++;
            tick();
        end
        chk("tmo_len", n, 4096);
        chk("tmo_state", state, 4);
        chk("tmo_terr", timeout_err, 1);
        chk("tmo_serr", sync_err, 0);
        n = 0;
        while (state == 3'd4 && n < 200) begin
            n++;
            tick();
        end
        tick();
        chk("tmo_beat_d", last_beat, 8'hA5);
        chk("tmo_wait", state, 2);
        frame();

        start = 1'b1; tick(); start = 1'b0;
        chk("ign_state", state, 3);
        chk("ign_fc", frame_count, 1);
        chk("ign_terr", timeout_err, 1);
        ev_ov = 1'b1; tick(); ev_ov = 1'b0;
        chk("ovf_one", overflow_count, 1);
        ev_halt = 1'b1; tick(); ev_halt = 1'b0;
        chk("halt_one", halt_count, 1);
        ev_ov = 1'b1;
        repeat (69999) tick();
        ev_ov = 1'b0;
        chk("ovf_sat", overflow_count, 16'hFFFF);
        chk("halt_keep", halt_count, 1);
        stop = 1'b1; ev_tu = 1'b1; tick(); stop = 1'b0; ev_tu = 1'b0;
        chk("stopsync_state", state, 0);
        chk("stopsync_serr", sync_err, 0);
        chk("stopsync_tvalid", cfg_if.tvalid, 0);

        cfg_if.tready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("mid_tvalid", cfg_if.tvalid, 1);
        b0 = beats;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_tvalid0", cfg_if.tvalid, 0);
        chk("mid_state", state, 0);
        chk("mid_tdata", cfg_if.tdata, 8'h01);
        chk("mid_nobeat", beats, b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
